alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width; it is derived from WIDTH and is not overridden.
REQ-003 Port: clk  input  1  rising-edge clock; the block has this single clock domain only.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  request valid.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: op  input  4  operation code, encoded per REQ-013.
REQ-008 Port: a, b  input  WIDTH each  operands.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: result  output  WIDTH  primary result.
REQ-012 Port: hi, lo  output  WIDTH each  multiply/divide registers; overflow, zero, div_zero  output  1 each  status flags.

Function
REQ-013 Opcodes SHALL be: 0000 addu; 0001 add; 0010 subu; 0011 sub; 0100 nand; 0101 nor; 0110 multu; 0111 sll; 1000 srl; 1001 sla (identical to sll); 1010 sra; 1011 mult (signed); 1100 divu; 1101 div (signed); 1110 slt; 1111 sltu.
REQ-014 A request SHALL be accepted on any clk edge where in_valid && in_ready; in_ready = (state==IDLE) && !out_valid.
REQ-015 The FSM SHALL have three states: IDLE, ITER, HOLD. IDLE goes to HOLD on accepting a single-cycle op, and to ITER on accepting a mult/div op. ITER goes to HOLD after WIDTH iterations. HOLD goes to IDLE on the edge where out_ready is high.
REQ-016 Single-cycle ops (add, sub, logic, shift, slt) SHALL assert out_valid on the first edge after acceptance (latency 1).
REQ-017 Mult/div ops SHALL run one radix-2 shift-add or restoring-subtract step per cycle and assert out_valid WIDTH+1 edges after acceptance.
REQ-018 result, flags, hi and lo SHALL stay stable while out_valid && !out_ready.
REQ-019 add/sub results SHALL wrap modulo 2^WIDTH.
REQ-020 overflow SHALL be set only for add and sub on signed overflow. For add: a and b have equal sign and the sum's sign differs. For sub: a and b have different sign and the result's sign differs from a. For all other ops overflow SHALL be 0.
REQ-021 Shifts SHALL use b[SHW-1:0] only; upper bits of b are ignored. sra replicates a[WIDTH-1].
REQ-022 slt and sltu SHALL return 1 (zero-extended) when a < b, signed and unsigned respectively, and 0 otherwise.
REQ-023 zero SHALL equal (result == 0) for single-cycle ops, and (lo == 0) for mult/div.
REQ-024 For mult/div, result SHALL be 0. hi and lo SHALL update only on completion and retain their value across non-mult/div ops.
REQ-025 Multiply: {hi,lo} = full 2*WIDTH-bit product, signed for mult, unsigned for multu.
REQ-026 Divide: lo = quotient and hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-027 Divide by zero (b==0): div_zero=1, lo = all ones, hi = a. The op still takes WIDTH+1 cycles. div_zero SHALL be 0 for all other cases.
REQ-028 Signed most-negative / -1: lo = most-negative value, hi = 0, div_zero = 0.
REQ-029 in_valid asserted while in_ready is low SHALL be ignored; no request is queued.
REQ-030 Acceptance and out_ready in the same cycle cannot occur, because in_ready is low while out_valid is high; a new request is accepted at the earliest one cycle after the handshake.

Reset
REQ-031 When rst_n is low, the block SHALL immediately set state=IDLE and out_valid=0, and clear result, hi, lo, overflow, zero and div_zero to 0. in_ready becomes 1 one cycle after rst_n deasserts.
REQ-032 Reset during ITER or HOLD SHALL abort the operation, discard the partial result, and clear hi and lo.

Verification
REQ-033 WIDTH=32, add a=0x7FFFFFFF b=1 -> after 1 cycle result=0x80000000, overflow=1; the same operands with addu -> overflow=0.
REQ-034 WIDTH=32, mult a=0xFFFFFFFE (-2) b=3 -> out_valid at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 div a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=7 b=0 -> div_zero=1, lo=0xFFFFFFFF, hi=7.
REQ-036 sra a=0x80000000 b=0x00000024 (shift 4) -> result=0xF8000000. srl on the same operands -> 0x08000000.
REQ-037 out_ready held low for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; in_ready=1 one cycle after out_ready rises.
REQ-038 rst_n pulsed low at iteration 10 of a divu -> out_valid=0, hi=lo=0 immediately; the next sltu a=1 b=2 -> result=1 after 1 cycle.

Source files
------------

// File: rtl/alu_iter_if.sv
// Request/response bundle for the iterative ALU: operation handshake in,
// result handshake out, plus the hi/lo registers and status flags.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             overflow;
  logic             zero;
  logic             div_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, hi, lo, overflow, zero, div_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, hi, lo, overflow, zero, div_zero
  );
endinterface

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle arithmetic/logic/shift ops, plus radix-2
// shift-add multiply and restoring divide that run one step per clock.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_iter_if.slave    bus
);

  typedef enum logic [3:0] {
    OP_ADDU = 4'b0000, OP_ADD  = 4'b0001, OP_SUBU = 4'b0010, OP_SUB   = 4'b0011,
    OP_NAND = 4'b0100, OP_NOR  = 4'b0101, OP_MULTU = 4'b0110, OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000, OP_SLA  = 4'b1001, OP_SRA  = 4'b1010, OP_MULT  = 4'b1011,
    OP_DIVU = 4'b1100, OP_DIV  = 4'b1101, OP_SLT  = 4'b1110, OP_SLTU  = 4'b1111
  } op_e;

  typedef enum logic [1:0] {IDLE, ITER, HOLD} state_e;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  function automatic logic is_iter(op_e o);
    return (o == OP_MULTU) || (o == OP_MULT) || (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic is_mul(op_e o);
    return (o == OP_MULTU) || (o == OP_MULT);
  endfunction

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_in;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               neg_q, neg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic               overflow_q, overflow_d, zero_q, zero_d, div_zero_q, div_zero_d;
  logic               out_valid_q, out_valid_d, rdy_q;
  logic               in_ready;

  // Operand conditioning at acceptance: signed ops run on magnitudes.
  logic               sgn_in, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // One iteration step for each engine.
  logic [WIDTH:0]     mul_sum, div_sh, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Single-cycle datapath on the latched operands.
  logic [WIDTH-1:0]   sum, diff, alu;
  logic               alu_ov;
  logic [SHW-1:0]     sh;

  assign in_ready = (state_q == IDLE) && !out_valid_q && rdy_q;

  assign op_in  = op_e'(bus.op);
  assign sgn_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg  = sgn_in & bus.a[WIDTH-1];
  assign b_neg  = sgn_in & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, m_q};
  assign div_next  = div_trial[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign sh   = b_q[SHW-1:0];

  always_comb begin
    alu    = '0;
    alu_ov = 1'b0;
    unique case (op_q)
      OP_ADDU:         alu = sum;
      OP_ADD: begin
        alu    = sum;
        alu_ov = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUBU:         alu = diff;
      OP_SUB: begin
        alu    = diff;
        alu_ov = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NAND:         alu = ~(a_q & b_q);
      OP_NOR:          alu = ~(a_q | b_q);
      OP_SLL, OP_SLA:  alu = a_q << sh;
      OP_SRL:          alu = a_q >> sh;
      OP_SRA:          alu = $signed(a_q) >>> sh;
      OP_SLT:          alu[0] = $signed(a_q) < $signed(b_q);
      OP_SLTU:         alu[0] = a_q < b_q;
      default:         alu = '0;
    endcase
  end

  // NOTE: every _d starts from its _q so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          op_d   = op_in;
          a_d    = bus.a;
          b_d    = bus.b;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (is_mul(op_in)) begin
            m_d   = a_mag;
            acc_d = {{WIDTH{1'b0}}, b_mag};
          end else begin
            m_d   = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
          end
          state_d = is_iter(op_in) ? ITER : HOLD;
        end
      end
      ITER: begin
        acc_d = is_mul(op_q) ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = HOLD;
      end
      HOLD: begin
        if (!out_valid_q) begin
          // First HOLD cycle publishes the result; later cycles just wait.
          out_valid_d = 1'b1;
          overflow_d  = 1'b0;
          div_zero_d  = 1'b0;
          if (is_mul(op_q)) begin
            result_d = '0;
            hi_d     = prod_fix[2*WIDTH-1:WIDTH];
            lo_d     = prod_fix[WIDTH-1:0];
            zero_d   = (prod_fix[WIDTH-1:0] == '0);
          end else if (is_iter(op_q)) begin
            result_d = '0;
            if (b_q == '0) begin
              div_zero_d = 1'b1;
              hi_d       = a_q;
              lo_d       = '1;
              zero_d     = 1'b0;
            end else begin
              hi_d   = rem_fix;
              lo_d   = quo_fix;
              zero_d = (quo_fix == '0);
            end
          end else begin
            result_d   = alu;
            overflow_d = alu_ov;
            zero_d     = (alu == '0);
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADDU;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=32 with hand-computed expectations.
module tb_alu_iter;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] ADDU = 4'h0, ADD = 4'h1, SUBU = 4'h2, SUB = 4'h3,
                         NAND = 4'h4, NOR = 4'h5, MULTU = 4'h6, SLL = 4'h7,
                         SRL = 4'h8, SLA = 4'h9, SRA = 4'hA, MULT = 4'hB,
                         DIVU = 4'hC, DIV = 4'hD, SLT = 4'hE, SLTU = 4'hF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("send_ready", 64'(bus.in_ready), 64'd1);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int e_lat,
                        input logic [W-1:0] e_res, input logic [W-1:0] e_hi,
                        input logic [W-1:0] e_lo, input logic e_ov, input logic e_z,
                        input logic e_dz);
    int lat;
    send(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"},    64'(lat),          64'(e_lat));
    check({tag, "_res"},    64'(bus.result),   64'(e_res));
    check({tag, "_hi"},     64'(bus.hi),       64'(e_hi));
    check({tag, "_lo"},     64'(bus.lo),       64'(e_lo));
    check({tag, "_ov"},     64'(bus.overflow), 64'(e_ov));
    check({tag, "_zero"},   64'(bus.zero),     64'(e_z));
    check({tag, "_dz"},     64'(bus.div_zero), 64'(e_dz));
    pop();
    check({tag, "_ready"},  64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 4'h0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_valid",  64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result),    64'd0);
    check("rst_hi",     64'(bus.hi),        64'd0);
    check("rst_lo",     64'(bus.lo),        64'd0);
    check("rst_flags",  64'({bus.overflow, bus.zero, bus.div_zero}), 64'd0);
    check("rst_ready",  64'(bus.in_ready),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_ready0", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("rel_ready1", 64'(bus.in_ready), 64'd1);

    // Single-cycle ops; hi/lo remain at their reset value.
    run_op("add_ovf",  ADD,  32'h7FFF_FFFF, 32'h1,          1, 32'h8000_0000, 0, 0, 1, 0, 0);
    run_op("addu",     ADDU, 32'h7FFF_FFFF, 32'h1,          1, 32'h8000_0000, 0, 0, 0, 0, 0);
    run_op("sub_ovf",  SUB,  32'h8000_0000, 32'h1,          1, 32'h7FFF_FFFF, 0, 0, 1, 0, 0);
    run_op("subu_z",   SUBU, 32'h5,         32'h5,          1, 32'h0,         0, 0, 0, 1, 0);
    run_op("nand",     NAND, 32'hF0F0_F0F0, 32'hFF00_FF00,  1, 32'h0FFF_0FFF, 0, 0, 0, 0, 0);
    run_op("nor",      NOR,  32'hF0F0_F0F0, 32'h0F0F_0F0F,  1, 32'h0,         0, 0, 0, 1, 0);
    run_op("sra",      SRA,  32'h8000_0000, 32'h0000_0024,  1, 32'hF800_0000, 0, 0, 0, 0, 0);
    run_op("srl",      SRL,  32'h8000_0000, 32'h0000_0024,  1, 32'h0800_0000, 0, 0, 0, 0, 0);
    run_op("sll",      SLL,  32'h1,         32'h0000_0021,  1, 32'h2,         0, 0, 0, 0, 0);
    run_op("sla",      SLA,  32'h3,         32'hFFFF_FFE2,  1, 32'hC,         0, 0, 0, 0, 0);
    run_op("slt",      SLT,  32'hFFFF_FFFF, 32'h1,          1, 32'h1,         0, 0, 0, 0, 0);
    run_op("sltu",     SLTU, 32'hFFFF_FFFF, 32'h1,          1, 32'h0,         0, 0, 0, 1, 0);

    // Iterative ops complete WIDTH+1 edges after acceptance.
    run_op("mult",     MULT,  32'hFFFF_FFFE, 32'h3, 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0, 0);
    run_op("multu",    MULTU, 32'hFFFF_FFFE, 32'h3, 33, 0, 32'h0000_0002, 32'hFFFF_FFFA, 0, 0, 0);
    run_op("hilo_keep", ADDU, 32'h1,         32'h1,  1, 32'h2, 32'h2, 32'hFFFF_FFFA, 0, 0, 0);
    run_op("div_neg",  DIV,   32'hFFFF_FFF9, 32'h2, 33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
    run_op("div_min",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 0, 32'h0, 32'h8000_0000, 0, 0, 0);
    run_op("divu_big", DIVU,  32'd100,       32'd7, 33, 0, 32'd2, 32'd14, 0, 0, 0);
    run_op("divu_z",   DIVU,  32'h7,         32'h0, 33, 0, 32'h7, 32'hFFFF_FFFF, 0, 0, 1);

    // Back-pressure: outputs hold, in_ready stays low, stray in_valid is dropped.
    send(ADDU, 32'd3, 32'd4);
    wait_valid(lat);
    check("stall_lat", 64'(lat), 64'd1);
    bus.op       = SUBU;
    bus.a        = 32'd9;
    bus.b        = 32'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_res",   64'(bus.result),    64'd7);
      check("stall_lo",    64'(bus.lo),        64'hFFFF_FFFF);
      check("stall_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.in_valid = 1'b0;
    pop();
    check("stall_rel_ready", 64'(bus.in_ready),  64'd1);
    check("stall_rel_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_queue", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a divide aborts it and clears hi/lo.
    send(DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    check("mid_valid", 64'(bus.out_valid), 64'd0);
    check("mid_hi",    64'(bus.hi),        64'h7);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_hi",    64'(bus.hi),        64'd0);
    check("abort_lo",    64'(bus.lo),        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", 64'(bus.out_valid), 64'd0);
    run_op("post_sltu", SLTU, 32'h1, 32'h2, 1, 32'h1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
